uart_host_sequencer: RTL and testbench
======================================

# uart_host_sequencer

Bus-master controller for the four-register UART peripheral (status, interrupt mask, data, baud divisor). It sits between on-chip requesters and the peripheral's CPU-style bus.
- After reset it programs the baud divisor and interrupt mask.
- It then services the interrupt line by polling status and draining received bytes into a small RX FIFO.
- It schedules transmit bytes from a valid/ready requester into the data register when the transmitter is idle.

## Interface
- BAUD_DIV, 8'd26, value written to baud register (addr 2'b11) at configuration
- INT_MASK, 8'h02, value written to interrupt-mask register (addr 2'b01)
- FIFO_DEPTH, 4, RX FIFO entries; power of two, ≥2
- POLL_PERIOD, 256, forced-poll interval in cycles (used only with UART_SEQ_POLL_EN)
- CLK  input  1  sole clock, rising edge
- NRST  input  1  asynchronous active-low reset
- BUS_ADDR  output  2  register address: 00 status, 01 int mask, 10 data, 11 baud
- BUS_NCS  output  1  negative chip select
- BUS_NO  output  1  negative read enable
- BUS_NW  output  1  negative write enable
- BUS_DATA  inout  8  shared data bus; driven only during write strobes, else Z
- BUS_NINT  input  1  negative interrupt from peripheral
- TX_DATA  input  8  byte to transmit; stable while TX_VALID=1
- TX_VALID  input  1  requester has a byte
- TX_READY  output  1  byte accepted this cycle
- RX_DATA  output  8  FIFO head
- RX_VALID  output  1  FIFO non-empty
- RX_READY  input  1  consumer pops head
- CFG_DONE  output  1  configuration complete

## Operation
- Status bits: bit0 = TX busy, bit1 = RX full. Other bits are ignored.
- FSM states: CFG_BAUD → GAP → CFG_INT → GAP → IDLE; IDLE → RD_STAT → GAP → EVAL; EVAL → RD_DATA | WR_DATA | IDLE; RD_DATA/WR_DATA → GAP → IDLE.
- GAP returns to the state recorded as next.
- IDLE moves to RD_STAT when BUS_NINT=0 or TX_VALID=1; otherwise it stays.
- EVAL priority:
  - stat[1]=1 and FIFO not full → RD_DATA.
  - Else stat[0]=0 and TX_VALID=1 → WR_DATA.
  - Else → IDLE.
- RX pending with a full FIFO: the byte is left in the peripheral. Interrupt stays asserted and is re-polled; TX may still be served.
- RD_DATA pushes the sampled byte into the FIFO.
- WR_DATA drives TX_DATA on BUS_DATA and asserts TX_READY for that cycle only.
- FIFO push and pop may occur in the same cycle. Pop when empty is ignored. Count width is $clog2(FIFO_DEPTH+1).
- Reset values: BUS_NCS=BUS_NO=BUS_NW=1, BUS_ADDR=00, BUS_DATA=Z, TX_READY=0, RX_VALID=0, RX_DATA=0, CFG_DONE=0, FIFO empty, state CFG_BAUD.
- Reset mid-access: strobes go high and DATA is released immediately (asynchronously). The FIFO is cleared and configuration reruns after release.

## Timing
- Every access is one strobe cycle followed by one GAP cycle with all strobes high and DATA Z.
- Write strobe: BUS_NCS=0, BUS_NW=0, BUS_ADDR and BUS_DATA valid; the peripheral captures on the rising edge ending the strobe.
- Read strobe: BUS_NCS=0, BUS_NO=0; the host samples BUS_DATA on the rising edge ending the strobe.
- BUS_NO and BUS_NW are never low together.
- Config sequence: first edge after NRST release starts the baud strobe (cycle 1), then GAP, int strobe (cycle 3), GAP. CFG_DONE=1 from cycle 5 and stays high until reset.
- Interrupt-to-RX latency: NINT low seen in IDLE gives RD_STAT the next cycle. RX_VALID rises 5 cycles after the IDLE decision (RD_STAT, GAP, EVAL, RD_DATA, push visible after GAP edge).
- TX_READY pulses exactly one cycle per accepted byte; minimum 5 cycles between acceptances.

## Configuration
- UART_SEQ_POLL_EN defined:
  - A down-counter reloads to POLL_PERIOD-1 on every RD_STAT.
  - At zero in IDLE it forces RD_STAT even with BUS_NINT=1 and TX_VALID=0. This covers masked interrupt sources.
- Undefined: no counter; status is read only on BUS_NINT=0 or TX_VALID=1.

## Structure
- Package uart_seq_pkg holds:
  - Register address constants (ADDR_STAT, ADDR_INT, ADDR_DATA, ADDR_BAUD).
  - Status bit indices (STAT_TXBUSY=0, STAT_RXFULL=1).
  - The FSM state enum.
- One sub-module: seq_rx_fifo, a synchronous FIFO (DEPTH, WIDTH=8) with async active-low reset and push/pop/full/empty/head.

## Test plan
- Reset release → baud write of 8'd26 to addr 11 at cycle 1, 8'h02 to addr 01 at cycle 3; CFG_DONE=1 at cycle 5; DATA Z in every GAP.
- Model sets stat=8'h02 with data 8'hA5 and pulls NINT low → status read, data read at addr 10; RX_DATA=8'hA5, RX_VALID=1.
- TX_VALID with TX_DATA=8'h3C, stat bit0=1 for two polls then 0 → no write while busy; a single write of 8'h3C and a single TX_READY pulse.
- Five RX bytes with RX_READY=0, FIFO_DEPTH=4 → four bytes stored and no fifth RD_DATA. Pop one → fifth byte read on the next poll; order preserved.
- NRST low during a write strobe → NW/NCS high and DATA Z in the same cycle; FIFO empty; after release the config sequence repeats.
- With UART_SEQ_POLL_EN and POLL_PERIOD=16, NINT held high and stat=8'h02 → status read every 16 cycles, byte captured.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared constants and FSM state type for the UART host sequencer.
package uart_seq_pkg;

  localparam logic [1:0] ADDR_STAT = 2'b00;
  localparam logic [1:0] ADDR_INT  = 2'b01;
  localparam logic [1:0] ADDR_DATA = 2'b10;
  localparam logic [1:0] ADDR_BAUD = 2'b11;

  localparam int unsigned STAT_TXBUSY = 0;
  localparam int unsigned STAT_RXFULL = 1;

  typedef enum logic [2:0] {
    StCfgBaud,
    StCfgInt,
    StIdle,
    StRdStat,
    StEval,
    StRdData,
    StWrData,
    StGap
  } seq_state_e;

endpackage

// File: rtl/seq_rx_fifo.sv
// Synchronous RX FIFO; head reads as zero while the FIFO is empty.
module seq_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_host_sequencer.sv
// Bus master for the four-register UART: configures it, drains RX into a FIFO, schedules TX.
// Define UART_SEQ_POLL_EN to add a periodic forced status poll.
module uart_host_sequencer
  import uart_seq_pkg::*;
#(
  parameter logic [7:0]  BAUD_DIV    = 8'd26,
  parameter logic [7:0]  INT_MASK    = 8'h02,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned POLL_PERIOD = 256
) (
  input  logic       CLK,
  input  logic       NRST,
  output logic [1:0] BUS_ADDR,
  output logic       BUS_NCS,
  output logic       BUS_NO,
  output logic       BUS_NW,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_NINT,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       CFG_DONE
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (POLL_PERIOD < 2) begin : g_bad_poll
    $error("POLL_PERIOD must be at least 2");
  end

  seq_state_e state_q, state_d;
  seq_state_e gap_next_q, gap_next_d;
  logic       run_q;
  logic [1:0] stat_q, stat_d;
  logic       cfg_done_q, cfg_done_d;
  logic       fifo_full, fifo_empty, fifo_push;
  logic       poll_due;
  logic       bus_drive;
  logic [7:0] bus_wdata;

  always_comb begin
    state_d    = state_q;
    gap_next_d = gap_next_q;
    stat_d     = stat_q;
    case (state_q)
      StCfgBaud: begin
        // Holds until the first edge after reset release.
        if (run_q) begin
          state_d    = StGap;
          gap_next_d = StCfgInt;
        end
      end
      StCfgInt: begin
        state_d    = StGap;
        gap_next_d = StIdle;
      end
      StIdle: begin
        if (!BUS_NINT || TX_VALID || poll_due) state_d = StRdStat;
      end
      StRdStat: begin
        stat_d     = {BUS_DATA[STAT_RXFULL], BUS_DATA[STAT_TXBUSY]};
        state_d    = StGap;
        gap_next_d = StEval;
      end
      StEval: begin
        // RX drains first; a full FIFO leaves the byte in the peripheral.
        if (stat_q[STAT_RXFULL] && !fifo_full)         state_d = StRdData;
        else if (!stat_q[STAT_TXBUSY] && TX_VALID)     state_d = StWrData;
        else                                           state_d = StIdle;
      end
      StRdData, StWrData: begin
        state_d    = StGap;
        gap_next_d = StIdle;
      end
      StGap:   state_d = gap_next_q;
      default: state_d = StCfgBaud;
    endcase
  end

  assign cfg_done_d = cfg_done_q || (state_d == StIdle);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q    <= StCfgBaud;
      gap_next_q <= StCfgInt;
      run_q      <= 1'b0;
      stat_q     <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_next_q <= gap_next_d;
      run_q      <= 1'b1;
      stat_q     <= stat_d;
      cfg_done_q <= cfg_done_d;
    end
  end

`ifdef UART_SEQ_POLL_EN
  localparam int unsigned PollW = $clog2(POLL_PERIOD);

  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;

  // Reload on entry to RD_STAT so consecutive forced polls are POLL_PERIOD cycles apart.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (state_d == StRdStat)     poll_cnt_d = PollW'(POLL_PERIOD - 1);
    else if (poll_cnt_q != '0)   poll_cnt_d = poll_cnt_q - PollW'(1);
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) poll_cnt_q <= PollW'(POLL_PERIOD - 1);
    else       poll_cnt_q <= poll_cnt_d;
  end

  assign poll_due = (poll_cnt_q == '0);
`else
  assign poll_due = 1'b0;
`endif

  // Strobes decode from registered state, gated by run_q so reset releases them at once.
  always_comb begin
    BUS_NCS   = 1'b1;
    BUS_NO    = 1'b1;
    BUS_NW    = 1'b1;
    BUS_ADDR  = ADDR_STAT;
    bus_drive = 1'b0;
    bus_wdata = '0;
    TX_READY  = 1'b0;
    if (run_q) begin
      case (state_q)
        StCfgBaud: begin
          BUS_NCS   = 1'b0;
          BUS_NW    = 1'b0;
          BUS_ADDR  = ADDR_BAUD;
          bus_drive = 1'b1;
          bus_wdata = BAUD_DIV;
        end
        StCfgInt: begin
          BUS_NCS   = 1'b0;
          BUS_NW    = 1'b0;
          BUS_ADDR  = ADDR_INT;
          bus_drive = 1'b1;
          bus_wdata = INT_MASK;
        end
        StWrData: begin
          BUS_NCS   = 1'b0;
          BUS_NW    = 1'b0;
          BUS_ADDR  = ADDR_DATA;
          bus_drive = 1'b1;
          bus_wdata = TX_DATA;
          TX_READY  = 1'b1;
        end
        StRdStat: begin
          BUS_NCS  = 1'b0;
          BUS_NO   = 1'b0;
          BUS_ADDR = ADDR_STAT;
        end
        StRdData: begin
          BUS_NCS  = 1'b0;
          BUS_NO   = 1'b0;
          BUS_ADDR = ADDR_DATA;
        end
        default: ;
      endcase
    end
  end

  assign BUS_DATA  = bus_drive ? bus_wdata : 8'hzz;
  assign CFG_DONE  = cfg_done_q;
  assign fifo_push = (state_q == StRdData);
  assign RX_VALID  = !fifo_empty;

  seq_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk_i       (CLK),
    .rst_ni      (NRST),
    .push_i      (fifo_push),
    .push_data_i (BUS_DATA),
    .pop_i       (RX_READY),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (RX_DATA)
  );

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Bench for uart_host_sequencer: peripheral model plus write and RX scoreboards.
module tb_uart_host_sequencer;
  import uart_seq_pkg::*;

`ifdef UART_SEQ_POLL_EN
  localparam int unsigned PollPeriod = 16;
`else
  localparam int unsigned PollPeriod = 256;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [1:0] bus_addr;
  logic       bus_ncs, bus_no, bus_nw;
  wire  [7:0] bus_data;
  logic       bus_nint = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       cfg_done;

  always #5 clk = ~clk;

  uart_host_sequencer #(
    .BAUD_DIV    (8'd26),
    .INT_MASK    (8'h02),
    .FIFO_DEPTH  (4),
    .POLL_PERIOD (PollPeriod)
  ) dut (
    .CLK      (clk),
    .NRST     (nrst),
    .BUS_ADDR (bus_addr),
    .BUS_NCS  (bus_ncs),
    .BUS_NO   (bus_no),
    .BUS_NW   (bus_nw),
    .BUS_DATA (bus_data),
    .BUS_NINT (bus_nint),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .CFG_DONE (cfg_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral model. Outside write strobes it pulls the bus to 00, so any stray DUT drive shows.
  logic [7:0] periph_out = '0;
  logic       nint_force = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_exp[$];
  logic [9:0] wr_exp[$];
  int busy_cnt = 0;
  int stat_reads = 0, data_reads = 0, tx_ready_cnt = 0;
  int cycle = 0, last_stat_cycle = 0, stat_gap = 0;
  logic wr_strobe, rd_strobe;

  assign wr_strobe = !bus_ncs && !bus_nw;
  assign rd_strobe = !bus_ncs && !bus_no;
  assign bus_data  = wr_strobe ? 8'hzz : (rd_strobe ? periph_out : 8'h00);

  always @(negedge clk) begin
    if (nrst) begin
      cycle++;
      check("strobe_excl", 32'(bus_no | bus_nw), 32'd1);
      if (bus_ncs) check("bus_release", 32'(bus_data), 32'h00);
      if (wr_strobe) begin
        check("wr_pending", 32'(wr_exp.size() > 0), 32'd1);
        if (wr_exp.size() > 0) check("wr_addr_data", 32'({bus_addr, bus_data}), 32'(wr_exp.pop_front()));
        if (bus_addr == ADDR_DATA) check("wr_while_busy", 32'(busy_cnt), 32'd0);
      end
      if (rd_strobe && bus_addr == ADDR_STAT) begin
        periph_out = {6'b0, rx_q.size() != 0, busy_cnt != 0};
        if (busy_cnt > 0) busy_cnt--;
        stat_reads++;
        stat_gap = cycle - last_stat_cycle;
        last_stat_cycle = cycle;
      end else if (rd_strobe && bus_addr == ADDR_DATA) begin
        check("rd_pending", 32'(rx_q.size() > 0), 32'd1);
        periph_out = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        data_reads++;
      end
      if (rx_valid && rx_ready) begin
        check("rx_exp_pending", 32'(rx_exp.size() > 0), 32'd1);
        if (rx_exp.size() > 0) check("rx_order", 32'(rx_data), 32'(rx_exp.pop_front()));
      end
      if (tx_ready) tx_ready_cnt++;
    end
    bus_nint = nint_force || (rx_q.size() == 0);
  end

  task automatic reset_and_cfg();
    nrst = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    wr_exp.delete();
    rx_exp.delete();
    rx_q.delete();
    busy_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", 32'({bus_ncs, bus_no, bus_nw}), 32'b111);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_z", 32'(bus_data), 32'h00);
    check("rst_outs", 32'({tx_ready, rx_valid, cfg_done}), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    wr_exp.push_back({ADDR_BAUD, 8'd26});
    wr_exp.push_back({ADDR_INT, 8'h02});
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("cfg_c1_strobe", 32'({bus_ncs, bus_no, bus_nw}), 32'b010);
    check("cfg_c1_baud", 32'({bus_addr, bus_data}), 32'({2'b11, 8'd26}));
    @(negedge clk);
    check("cfg_c2_gap", 32'({bus_ncs, cfg_done}), 32'b10);
    @(negedge clk);
    check("cfg_c3_strobe", 32'({bus_ncs, bus_no, bus_nw}), 32'b010);
    check("cfg_c3_int", 32'({bus_addr, bus_data}), 32'({2'b01, 8'h02}));
    @(negedge clk);
    check("cfg_c4_gap", 32'({bus_ncs, cfg_done}), 32'b10);
    @(negedge clk);
    check("cfg_c5_done", 32'(cfg_done), 32'd1);
  endtask

  task automatic inject(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_q.push_back(b);
    rx_exp.push_back(b);
  endtask

  task automatic wait_rx_valid(input int budget);
    int n = 0;
    @(negedge clk);
    while (!rx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rx_valid_timeout", 32'(rx_valid), 32'd1);
  endtask

  task automatic pop_rx();
    wait_rx_valid(100);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    tx_data  = b;
    tx_valid = 1'b1;
    wr_exp.push_back({ADDR_DATA, b});
    @(negedge clk);
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_accept_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  initial begin
    int s0, d0, t0, n;
    #1 nrst = 1'b0;
    reset_and_cfg();

    // RX path and interrupt-to-RX_VALID latency.
    inject(8'hA5);
    repeat (5) @(negedge clk);
`ifndef UART_SEQ_POLL_EN
    check("rx_lat_early", 32'(rx_valid), 32'd0);
`endif
    @(negedge clk);
    check("rx_lat_valid", 32'(rx_valid), 32'd1);
    check("rx_lat_data", 32'(rx_data), 32'hA5);
    pop_rx();

    // TX held off while the transmitter reports busy for two polls.
    s0 = stat_reads;
    t0 = tx_ready_cnt;
    busy_cnt = 2;
    send_tx(8'h3C);
    repeat (8) @(negedge clk);
    check("tx_single_pulse", 32'(tx_ready_cnt - t0), 32'd1);
    check("tx_busy_cleared", 32'(busy_cnt), 32'd0);
`ifndef UART_SEQ_POLL_EN
    check("tx_stat_polls", 32'(stat_reads - s0), 32'd3);
`endif

    // Five bytes into a four-entry FIFO with no consumer.
    d0 = data_reads;
    for (int i = 0; i < 5; i++) inject(8'(17 * (i + 1)));
    repeat (80) @(negedge clk);
    check("full_reads", 32'(data_reads - d0), 32'd4);
    check("full_left", 32'(rx_q.size()), 32'd1);
    check("full_valid", 32'(rx_valid), 32'd1);
    pop_rx();
    repeat (30) @(negedge clk);
    check("fifth_read", 32'(data_reads - d0), 32'd5);
    check("fifth_left", 32'(rx_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) pop_rx();
    @(negedge clk);
    check("drained_valid", 32'(rx_valid), 32'd0);
    check("drained_exp", 32'(rx_exp.size()), 32'd0);

    // Reset in the middle of a TX write strobe.
    inject(8'h77);
    wait_rx_valid(40);
    @(posedge clk);
    #1;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    n = 0;
    while (!wr_strobe && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midwr_strobe_seen", 32'(wr_strobe), 32'd1);
    nrst = 1'b0;
    #1;
    check("midwr_strobes", 32'({bus_ncs, bus_nw}), 32'b11);
    check("midwr_bus_z", 32'(bus_data), 32'h00);
    check("midwr_fifo_empty", 32'(rx_valid), 32'd0);
    check("midwr_tx_ready", 32'(tx_ready), 32'd0);
    reset_and_cfg();

`ifdef UART_SEQ_POLL_EN
    // Forced polling with the interrupt line held high.
    nint_force = 1'b1;
    inject(8'h6B);
    pop_rx();
    s0 = stat_reads;
    n = 0;
    while (stat_reads < s0 + 2 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("poll_count", 32'(stat_reads >= s0 + 2), 32'd1);
    check("poll_gap", 32'(stat_gap), 32'd16);
    nint_force = 1'b0;
`else
    s0 = stat_reads;
    repeat (300) @(negedge clk);
    check("no_idle_poll", 32'(stat_reads - s0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
